// File: rtl/fsm_addsub_ctrl_pkg.sv
// Shared state encodings and mux select codes for the FP add/sub control FSM
// and the datapath muxes it steers.
package fsm_addsub_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_OPS  = 4'd1,
    S_CMP_EXP   = 4'd2,
    S_ALIGN     = 4'd3,
    S_ADD       = 4'd4,
    S_NORM      = 4'd5,
    S_ROUND     = 4'd6,
    S_ROUND_ADJ = 4'd7,
    S_LOAD_OUT  = 4'd8,
    S_READY     = 4'd9
  } state_e;

  localparam logic [1:0] EXP_SEL_LARGE  = 2'b00;
  localparam logic [1:0] EXP_SEL_DEC    = 2'b01;
  localparam logic [1:0] EXP_SEL_INC    = 2'b10;
  localparam logic [1:0] EXP_SEL_ZERO   = 2'b11;

  localparam logic [1:0] MANT_SEL_ADDER = 2'b00;
  localparam logic [1:0] MANT_SEL_SHIFT = 2'b01;
  localparam logic [1:0] MANT_SEL_ULP   = 2'b10;
  localparam logic [1:0] MANT_SEL_ZERO  = 2'b11;

  // Alignment beyond the mantissa width only shifts everything out, so clamp it.
  function automatic logic [7:0] sat_diff(input logic [7:0] diff, input logic [7:0] lim);
    return (diff > lim) ? lim : diff;
  endfunction

endpackage

// File: rtl/fsm_addsub_ctrl_if.sv
// Handshake and datapath control bundle between the FPU top / datapath (master)
// and the add/sub sequencer (slave).
interface fsm_addsub_ctrl_if;
  logic       beg_FSM;
  logic       ack_FSM;
  logic [7:0] exp_diff;
  logic       add_ovf;
  logic       lead_one;
  logic       zero_flag;
  logic       round_up;

  logic       load_op_o;
  logic       load_exp_o;
  logic       load_mant_o;
  logic       shift_en_o;
  logic       shift_left_o;
  logic [1:0] exp_sel_o;
  logic [1:0] mant_sel_o;
  logic       load_out_o;
  logic       busy_o;
  logic       ready_o;

  modport master (
    output beg_FSM, ack_FSM, exp_diff, add_ovf, lead_one, zero_flag, round_up,
    input  load_op_o, load_exp_o, load_mant_o, shift_en_o, shift_left_o,
           exp_sel_o, mant_sel_o, load_out_o, busy_o, ready_o
  );

  modport slave (
    input  beg_FSM, ack_FSM, exp_diff, add_ovf, lead_one, zero_flag, round_up,
    output load_op_o, load_exp_o, load_mant_o, shift_en_o, shift_left_o,
           exp_sel_o, mant_sel_o, load_out_o, busy_o, ready_o
  );
endinterface

// File: rtl/fsm_addsub_ctrl_shift_count_reg.sv
// Shift counter shared by alignment (counts down) and normalisation (counts up).
module shift_count_reg #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_q
);
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (dec)  cnt_d = cnt_q - CNT_W'(1);
    else if (inc)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fsm_addsub_ctrl.sv
// Sequencer for the FP add/sub datapath: load, exponent compare, align, add,
// normalise, round (with one optional renormalising adjust), result load.
module fsm_addsub_ctrl
  import fsm_addsub_ctrl_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  fsm_addsub_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] NORM_MAX = CNT_W'(MANT_W + 1);

  state_e           state_q, state_d;
  logic             ovf_done_q, ovf_done_d;
  logic             rnd_done_q, rnd_done_d;
  logic             cnt_clr, cnt_load, cnt_dec, cnt_inc;
  logic [CNT_W-1:0] cnt_load_val, cnt_q;

  assign cnt_load_val = CNT_W'(sat_diff(bus.exp_diff, 8'(MANT_W + 2)));

  shift_count_reg #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .cnt_q    (cnt_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ovf_done_q <= 1'b0;
      rnd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_done_q <= ovf_done_d;
      rnd_done_q <= rnd_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ovf_done_d       = ovf_done_q;
    rnd_done_d       = rnd_done_q;
    cnt_clr          = 1'b0;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;
    cnt_inc          = 1'b0;
    bus.load_op_o    = 1'b0;
    bus.load_exp_o   = 1'b0;
    bus.load_mant_o  = 1'b0;
    bus.shift_en_o   = 1'b0;
    bus.shift_left_o = 1'b0;
    bus.exp_sel_o    = EXP_SEL_LARGE;
    bus.mant_sel_o   = MANT_SEL_ADDER;
    bus.load_out_o   = 1'b0;
    bus.busy_o       = (state_q != S_IDLE);
    bus.ready_o      = 1'b0;

    case (state_q)
      S_IDLE: if (bus.beg_FSM) state_d = S_LOAD_OPS;

      S_LOAD_OPS: begin
        bus.load_op_o = 1'b1;
        state_d       = S_CMP_EXP;
      end

      S_CMP_EXP: begin
        bus.load_exp_o = 1'b1;
        bus.exp_sel_o  = EXP_SEL_LARGE;
        cnt_load       = 1'b1;
        state_d        = (bus.exp_diff != 8'd0) ? S_ALIGN : S_ADD;
      end

      // Leave on the last count so exactly cnt shift cycles are spent here.
      S_ALIGN: begin
        bus.shift_en_o = 1'b1;
        cnt_dec        = 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_ADD;
      end

      S_ADD: begin
        bus.load_mant_o = 1'b1;
        bus.mant_sel_o  = MANT_SEL_ADDER;
        cnt_clr         = 1'b1;
        ovf_done_d      = 1'b0;
        rnd_done_d      = 1'b0;
        state_d         = S_NORM;
      end

      S_NORM: begin
        if (bus.zero_flag) begin
          bus.mant_sel_o  = MANT_SEL_ZERO;
          bus.exp_sel_o   = EXP_SEL_ZERO;
          bus.load_mant_o = 1'b1;
          bus.load_exp_o  = 1'b1;
          state_d         = S_LOAD_OUT;
        end else if (bus.add_ovf && !ovf_done_q) begin
          bus.shift_en_o  = 1'b1;
          bus.exp_sel_o   = EXP_SEL_INC;
          bus.load_exp_o  = 1'b1;
          ovf_done_d      = 1'b1;
          state_d         = S_ROUND;
        end else if (!bus.lead_one && (cnt_q < NORM_MAX)) begin
          bus.shift_en_o   = 1'b1;
          bus.shift_left_o = 1'b1;
          bus.exp_sel_o    = EXP_SEL_DEC;
          bus.load_exp_o   = 1'b1;
          cnt_inc          = 1'b1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: state_d = (bus.round_up && !rnd_done_q) ? S_ROUND_ADJ : S_LOAD_OUT;

      // A +1 ulp can carry out, so renormalise; rnd_done bounds this to once.
      S_ROUND_ADJ: begin
        bus.mant_sel_o  = MANT_SEL_ULP;
        bus.load_mant_o = 1'b1;
        rnd_done_d      = 1'b1;
        ovf_done_d      = 1'b0;
        state_d         = S_NORM;
      end

      S_LOAD_OUT: begin
        bus.load_out_o = 1'b1;
        state_d        = S_READY;
      end

      S_READY: begin
        bus.ready_o = 1'b1;
        if (bus.ack_FSM) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fsm_addsub_ctrl.sv
// Randomized bench: each operation is expanded from its parameters into the
// expected per-cycle input/output trace, then replayed against the DUT.
module tb_fsm_addsub_ctrl;
  localparam int MANT_W = 23;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsm_addsub_ctrl_if bus();

  fsm_addsub_ctrl #(.MANT_W(MANT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        beg, ack, ovf, lead, zero, rup;
    logic [7:0]  ed;
    logic [11:0] exp;
  } cyc_t;

  cyc_t tr[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {load_op, load_exp, load_mant, shift_en, shift_left, exp_sel, mant_sel, load_out, busy, ready}
  function automatic logic [11:0] ov(bit lop, bit lexp, bit lmant, bit sh, bit shl,
                                     logic [1:0] es, logic [1:0] ms, bit lout, bit busy, bit rdy);
    return {lop, lexp, lmant, sh, shl, es, ms, lout, busy, rdy};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.load_op_o, bus.load_exp_o, bus.load_mant_o, bus.shift_en_o, bus.shift_left_o,
            bus.exp_sel_o, bus.mant_sel_o, bus.load_out_o, bus.busy_o, bus.ready_o};
  endfunction

  // Inputs that the current state does not look at are randomized.
  function automatic cyc_t mk(input string tag, input logic [11:0] o);
    cyc_t c;
    c.tag  = tag;
    c.exp  = o;
    c.beg  = 1'($urandom);
    c.ack  = 1'($urandom);
    c.ovf  = 1'($urandom);
    c.lead = 1'($urandom);
    c.zero = 1'($urandom);
    c.rup  = 1'($urandom);
    c.ed   = 8'($urandom);
    return c;
  endfunction

  task automatic norm_pass(input bit ovf, input int nsh, inout int budget);
    cyc_t c;
    int   k;
    if (ovf) begin
      c = mk("norm_ovf", ov(0,1,0,1,0,2'b10,2'b00,0,1,0));
      c.zero = 0; c.ovf = 1;
      tr.push_back(c);
    end else begin
      k = (nsh < budget) ? nsh : budget;
      repeat (k) begin
        c = mk("norm_shl", ov(0,1,0,1,1,2'b01,2'b00,0,1,0));
        c.zero = 0; c.ovf = 0; c.lead = 0;
        tr.push_back(c);
      end
      budget -= k;
      c = mk("norm_exit", ov(0,0,0,0,0,2'b00,2'b00,0,1,0));
      c.zero = 0; c.ovf = 0; c.lead = (nsh > k) ? 1'b0 : 1'b1;
      tr.push_back(c);
    end
  endtask

  task automatic build_op(input int ed, input bit zero, input bit ovf, input int nsh, input bit rup,
                          input bit ovf2, input int nsh2, input int ackw, input int idle_pre);
    cyc_t c;
    int   budget;
    repeat (idle_pre) begin
      c = mk("idle_wait", '0); c.beg = 0; tr.push_back(c);
    end
    c = mk("idle_beg", '0); c.beg = 1; tr.push_back(c);
    tr.push_back(mk("load_ops", ov(1,0,0,0,0,2'b00,2'b00,0,1,0)));
    c = mk("cmp_exp", ov(0,1,0,0,0,2'b00,2'b00,0,1,0)); c.ed = 8'(ed); tr.push_back(c);
    repeat ((ed > MANT_W + 2) ? MANT_W + 2 : ed)
      tr.push_back(mk("align", ov(0,0,0,1,0,2'b00,2'b00,0,1,0)));
    tr.push_back(mk("add", ov(0,0,1,0,0,2'b00,2'b00,0,1,0)));
    budget = MANT_W + 1;
    if (zero) begin
      c = mk("norm_zero", ov(0,1,1,0,0,2'b11,2'b11,0,1,0)); c.zero = 1; tr.push_back(c);
    end else begin
      norm_pass(ovf, nsh, budget);
      c = mk("round", ov(0,0,0,0,0,2'b00,2'b00,0,1,0)); c.rup = rup; tr.push_back(c);
      if (rup) begin
        tr.push_back(mk("round_adj", ov(0,0,1,0,0,2'b00,2'b10,0,1,0)));
        norm_pass(ovf2, nsh2, budget);
        tr.push_back(mk("round2", ov(0,0,0,0,0,2'b00,2'b00,0,1,0)));
      end
    end
    tr.push_back(mk("load_out", ov(0,0,0,0,0,2'b00,2'b00,1,1,0)));
    repeat (ackw) begin
      c = mk("ready_hold", ov(0,0,0,0,0,2'b00,2'b00,0,1,1)); c.ack = 0; tr.push_back(c);
    end
    c = mk("ready_ack", ov(0,0,0,0,0,2'b00,2'b00,0,1,1)); c.ack = 1; tr.push_back(c);
  endtask

  task automatic run_trace(input int nmax);
    cyc_t c;
    int   i = 0;
    while (tr.size() > 0 && i < nmax) begin
      c = tr.pop_front();
      @(negedge clk);
      bus.beg_FSM   = c.beg;
      bus.ack_FSM   = c.ack;
      bus.exp_diff  = c.ed;
      bus.add_ovf   = c.ovf;
      bus.lead_one  = c.lead;
      bus.zero_flag = c.zero;
      bus.round_up  = c.rup;
      #1 chk(c.tag, dut_vec(), c.exp);
      i++;
    end
  endtask

  initial begin
    bus.beg_FSM = 0; bus.ack_FSM = 0; bus.exp_diff = '0; bus.add_ovf = 0;
    bus.lead_one = 1; bus.zero_flag = 0; bus.round_up = 0;
    repeat (2) @(negedge clk);
    bus.beg_FSM = 1;
    #1 chk("reset_state", dut_vec(), '0);
    @(negedge clk);
    bus.beg_FSM = 0;
    rst = 0;

    // directed: ed, zero, ovf, nsh, rup, ovf2, nsh2, ackw, idle_pre
    build_op(0,   0, 0, 0,  0, 0, 0, 0, 0); run_trace(1000);
    build_op(3,   0, 0, 0,  0, 0, 0, 0, 1); run_trace(1000);
    build_op(200, 0, 0, 0,  0, 0, 0, 0, 0); run_trace(1000);
    build_op(25,  0, 0, 0,  0, 0, 0, 0, 0); run_trace(1000);
    build_op(26,  0, 0, 0,  0, 0, 0, 0, 0); run_trace(1000);
    build_op(0,   0, 1, 0,  1, 0, 0, 0, 0); run_trace(1000);
    build_op(0,   0, 0, 30, 0, 0, 0, 0, 0); run_trace(1000);
    build_op(2,   1, 0, 0,  0, 0, 0, 0, 0); run_trace(1000);
    build_op(1,   0, 0, 0,  0, 0, 0, 5, 0); run_trace(1000);
    build_op(0,   0, 0, 22, 1, 0, 5, 0, 0); run_trace(1000);
    build_op(0,   0, 1, 0,  1, 1, 0, 0, 0); run_trace(1000);

    // reset while aligning: outputs drop in the same cycle, sequencer restarts
    build_op(10, 0, 0, 0, 0, 0, 0, 0, 0);
    run_trace(5);
    tr.delete();
    @(negedge clk);
    rst = 1;
    #1 chk("rst_mid_op", dut_vec(), '0);
    @(negedge clk);
    #1 chk("rst_held", dut_vec(), '0);
    rst = 0;
    build_op(4, 0, 0, 2, 1, 0, 1, 1, 0); run_trace(1000);

    for (int n = 0; n < 40; n++) begin
      build_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7)),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 30)) : int'($urandom_range(0, 3)),
               1'($urandom),
               ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)));
      run_trace(1000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
